dmem_responder: RTL

- Data-memory responder for the memory-access stage.
- It is the consumer end of the MemWrite control signal that the stage's control register produces.
- It accepts one load or store request at a time from the pipeline, services it against an internal word-addressed array with a fixed multi-cycle latency, and returns read data plus an error flag.
- It drives `stall`, which the pipeline uses to deassert the enable of its stage registers while an access is in flight.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder
// Data-memory responder for the memory-access stage. Accepts one load or
// store at a time, services it against an internal word-addressed array
// after a fixed LAT-cycle latency, and returns read data plus an error flag.
// While an access is in flight it raises `stall` so the pipeline holds its
// stage registers.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is only ever 1 in IDLE outside reset, so
// at most one request is outstanding. The response is a single-cycle
// resp_valid strobe with no back-pressure; resp_rdata/resp_err stay valid
// after the strobe until the next response replaces them.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid      pipeline presents a request
//   req_write      1 = store, 0 = load
//   req_addr       byte address (must be word aligned and in range)
//   req_wdata      store data
//   req_ready      request accepted this cycle
//   resp_valid     one-cycle response strobe
//   resp_rdata     load data; 0 for stores and errors
//   resp_err       misaligned / out-of-range flag, valid with resp_valid
//   stall          hold the pipeline stage registers
//   dbg_state      current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// LAT must be at least 1.
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(LAT + 1);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic req_bad;
    logic commit;

    // Misaligned, or any byte-address bit above the array's reach is set.
    assign req_bad = (req_addr[1:0] != 2'b00) ||
                     ((req_addr >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        // Skip BUSY entirely; the array is never touched.
                        state_d = S_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    // Last BUSY cycle: the access completes here, and the
                    // response registers change only now so the previous
                    // response stays readable during BUSY.
                    commit  = write_q;
                    rdata_d = write_q ? '0 : mem[idx_q];
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset on the commit edge aborts the store.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Reset wins over a simultaneous request.
    assign req_ready  = (state_q == S_IDLE) && req_valid && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    // Low in RESP so the pipeline advances on the edge that ends RESP.
    assign stall      = (state_q == S_BUSY) || ((state_q == S_IDLE) && req_valid);
    assign dbg_state  = state_q;

endmodule
